// File: rtl/nr_pkg.sv
// Shared types and Q-format constants for the Newton-Raphson reciprocal controller.
package nr_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSeed,
        StM1Req,
        StM1Wait,
        StM2Req,
        StM2Wait,
        StFin
    } nr_state_e;

    localparam logic [23:0] TWO_Q222   = 24'h800000;
    localparam logic [23:0] SAT_Q222   = 24'hFFFFFF;
    localparam logic [23:0] INIT_C_DEF = 24'hBA8241;

    // Product slices: d*x lands in Q2.46 but d<1 keeps it in [47:24] as Q2.22 (weight 2^-22 at bit 24
    // relative to Q0.24*Q2.22); x*t is Q4.44, so Q2.22 sits at [45:22].
    localparam int unsigned E_HI = 47;
    localparam int unsigned E_LO = 24;
    localparam int unsigned X_HI = 45;
    localparam int unsigned X_LO = 22;

endpackage

// File: rtl/nr_post.sv
// Combinational product post-processing: error term 2-e with clamp, and Q2.22 saturation of x*t.
module nr_post
    import nr_pkg::*;
(
    input  logic [47:0] p_i,
    output logic [23:0] t_o,
    output logic [23:0] x_o
);

    logic [23:0] e;
    logic        unused_low;

    assign unused_low = ^p_i[X_LO-1:0];

    always_comb begin
        e   = p_i[E_HI:E_LO];
        t_o = (e > TWO_Q222) ? 24'd0 : (TWO_Q222 - e);
        // Anything at or above 4.0 in Q4.44 cannot be represented in Q2.22.
        x_o = (|p_i[47:X_HI+1]) ? SAT_Q222 : p_i[X_HI:X_LO];
    end

endmodule

// File: rtl/nr_recip_ctrl.sv
// Newton-Raphson reciprocal controller driving a 24x24 sequential multiplier via start/ready.
module nr_recip_ctrl
    import nr_pkg::*;
#(
    parameter int unsigned ITER   = 3,
    parameter logic [23:0] INIT_C = INIT_C_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] d_in,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [23:0] y_out,
    output logic        mul_start,
    output logic [23:0] mul_a,
    output logic [23:0] mul_b,
    input  logic        mul_ready,
    input  logic [47:0] mul_p
);

    localparam logic [1:0] LAST_IT = 2'(ITER - 1);

    nr_state_e   state_q;
    logic [23:0] d_q;
    logic [23:0] x_q;
    logic [1:0]  it_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [23:0] y_q;
    logic        mul_start_q;
    logic [23:0] mul_a_q;
    logic [23:0] mul_b_q;

    logic [23:0] seed;
    logic [23:0] t_val;
    logic [23:0] x_new;

    // Linear seed 2.9142 - 2d; d>>1 re-expresses the Q0.24 divisor as 2d in Q2.22.
    assign seed = INIT_C - {1'b0, d_q[23:1]};

    nr_post u_post (
        .p_i (mul_p),
        .t_o (t_val),
        .x_o (x_new)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            d_q         <= '0;
            x_q         <= '0;
            it_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            y_q         <= '0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        d_q     <= d_in;
                        err_q   <= ~d_in[23];
                        busy_q  <= 1'b1;
                        state_q <= StSeed;
                    end
                end
                StSeed: begin
                    if (err_q) begin
                        state_q <= StFin;
                    end else begin
                        x_q         <= seed;
                        it_q        <= '0;
                        mul_a_q     <= d_q;
                        mul_b_q     <= seed;
                        // A multiplier left running across our reset keeps ready low; wait it out.
                        mul_start_q <= mul_ready;
                        state_q     <= StM1Req;
                    end
                end
                StM1Req, StM2Req: begin
                    if (mul_start_q) begin
                        mul_start_q <= 1'b0;
                        state_q     <= (state_q == StM1Req) ? StM1Wait : StM2Wait;
                    end else if (mul_ready) begin
                        mul_start_q <= 1'b1;
                    end
                end
                StM1Wait: begin
                    if (mul_ready) begin
                        mul_a_q     <= x_q;
                        mul_b_q     <= t_val;
                        mul_start_q <= 1'b1;
                        state_q     <= StM2Req;
                    end
                end
                StM2Wait: begin
                    if (mul_ready) begin
                        x_q <= x_new;
                        if (it_q == LAST_IT) begin
                            state_q <= StFin;
                        end else begin
                            it_q        <= it_q + 2'd1;
                            mul_a_q     <= d_q;
                            mul_b_q     <= x_new;
                            mul_start_q <= 1'b1;
                            state_q     <= StM1Req;
                        end
                    end
                end
                StFin: begin
                    y_q     <= err_q ? SAT_Q222 : x_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign y_out     = y_q;
    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_nr_recip_ctrl.sv
// Bench for nr_recip_ctrl with a behavioural 24x24 sequential multiplier as the downstream stage.
module tb_nr_recip_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] d_in = '0;
    logic        busy, done, err, mul_start;
    logic [23:0] y_out, mul_a, mul_b;
    logic        mul_ready = 1'b1;
    logic [47:0] mul_p = '0;

    int          checks = 0;
    int          errors = 0;
    logic [23:0] exp_y = '0;
    logic        exp_err = 1'b0;
    int          mul_pulses = 0;
    int          abandon_cnt = -1;
    logic [2:0]  m_cnt = '0;
    logic [23:0] a0 = '0;
    logic [23:0] b0 = '0;
    logic        prev_done = 1'b0;
    logic        prev_start = 1'b0;

    nr_recip_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .d_in      (d_in),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .y_out     (y_out),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_ready (mul_ready),
        .mul_p     (mul_p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic chk_near(input string nm, input longint act, input longint req);
        longint diff;
        diff = (act > req) ? act - req : req - act;
        checks++;
        if (diff > 2) begin
            errors++;
            $display("FAIL %s: got %0h want %0h +/-2", nm, act, req);
        end
    endtask

    // Reference: the iteration written as plain integer arithmetic on Q-format values.
    function automatic logic [23:0] nr_model(input logic [23:0] d);
        longint unsigned dd, x, e, t, p;
        if (!d[23]) return 24'hFFFFFF;
        dd = longint'(d);
        x  = 64'hBA8241 - (dd >> 1);
        for (int i = 0; i < 3; i++) begin
            e = (x * dd) >> 24;
            t = (e > 64'h800000) ? 64'd0 : 64'h800000 - e;
            p = x * t;
            x = ((p >> 46) != 0) ? 64'hFFFFFF : ((p >> 22) & 64'hFFFFFF);
        end
        return x[23:0];
    endfunction

    function automatic longint ideal(input logic [23:0] d);
        return (longint'(1) <<< 46) / longint'(d);
    endfunction

    // Sequential multiplier: ready drops on start, product valid four edges later.
    always @(posedge clk) begin
        if (mul_start && mul_ready) begin
            mul_ready  <= 1'b0;
            m_cnt      <= 3'd3;
            a0         <= mul_a;
            b0         <= mul_b;
            mul_pulses <= mul_pulses + 1;
        end else if (!mul_ready) begin
            if (m_cnt == 0) begin
                mul_ready <= 1'b1;
                mul_p     <= 48'(mul_a) * 48'(mul_b);
            end else begin
                m_cnt <= m_cnt - 3'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                chk("done_y", longint'(y_out), longint'(exp_y));
                chk("done_err", longint'(err), longint'(exp_err));
                chk("done_busy", longint'(busy), 0);
            end
            if (prev_done) chk("done_pulse", longint'(done), 0);
            if (mul_start) begin
                chk("start_single", longint'(prev_start), 0);
                chk("start_ready", longint'(mul_ready), 1);
            end
            if (!mul_ready && mul_pulses != abandon_cnt) begin
                chk("op_a_stable", longint'(mul_a), longint'(a0));
                chk("op_b_stable", longint'(mul_b), longint'(b0));
            end
        end
        prev_done  = done;
        prev_start = mul_start;
    end

    task automatic wait_done(output int n, output bit got);
        n   = 0;
        got = 1'b0;
        while (!got && n < 500) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            got = done;
        end
        chk("done_seen", longint'(got), 1);
    endtask

    task automatic run_op(input logic [23:0] d, input int exp_lat, input int exp_pulses,
                          input logic [23:0] lit);
        int n, base;
        bit got;
        @(negedge clk);
        start   = 1'b1;
        d_in    = d;
        exp_y   = nr_model(d);
        exp_err = ~d[23];
        base    = mul_pulses;
        @(posedge clk);
        #1;
        start = 1'b0;
        d_in  = 24'h123456;
        chk("busy_accept", longint'(busy), 1);
        wait_done(n, got);
        if (exp_lat > 0) chk("latency", longint'(n), longint'(exp_lat));
        if (exp_pulses >= 0) chk("mul_pulses", longint'(mul_pulses - base), longint'(exp_pulses));
        chk_near("lit_y", longint'(y_out), longint'(lit));
        if (d[23]) chk_near("ideal_y", longint'(y_out), ideal(d));
    endtask

    initial begin
        int  n, base;
        bit  got;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_flags", longint'({busy, done, err, mul_start}), 0);
        chk("rst_y", longint'(y_out), 0);
        chk("rst_ab", longint'({mul_a, mul_b}), 0);
        @(negedge clk);
        rst = 1'b0;

        chk_near("model_0p5", longint'(nr_model(24'h800000)), 64'h800000);
        chk_near("model_0p75", longint'(nr_model(24'hC00000)), 64'h555555);
        chk_near("model_max", longint'(nr_model(24'hFFFFFF)), 64'h400000);
        chk_near("model_0p625", longint'(nr_model(24'hA00000)), 64'h666666);

        run_op(24'h800000, 38, 6, 24'h800000);
        run_op(24'hC00000, 38, 6, 24'h555555);
        run_op(24'hFFFFFF, 38, 6, 24'h400000);
        run_op(24'h3FFFFF, 2, 0, 24'hFFFFFF);

        // Abandon an operation during the second iteration's x*t multiply.
        @(negedge clk);
        start   = 1'b1;
        d_in    = 24'hE00000;
        exp_y   = nr_model(24'hE00000);
        exp_err = 1'b0;
        base    = mul_pulses;
        @(posedge clk);
        #1;
        start = 1'b0;
        got   = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk);
            #1;
            got = (mul_pulses - base >= 4);
        end
        chk("reach_m2_wait", longint'(got), 1);
        @(posedge clk);
        #3;
        rst         = 1'b1;
        abandon_cnt = mul_pulses;
        #1;
        chk("midrst_flags", longint'({busy, done, err, mul_start}), 0);
        chk("midrst_y", longint'(y_out), 0);
        chk("midrst_ab", longint'({mul_a, mul_b}), 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(24'hA00000, 0, -1, 24'h666666);

        // Start held through the whole operation: ignored while busy, accepted right after done.
        @(negedge clk);
        start   = 1'b1;
        d_in    = 24'hC00000;
        exp_y   = nr_model(24'hC00000);
        exp_err = 1'b0;
        @(posedge clk);
        #1;
        d_in = 24'h900000;
        wait_done(n, got);
        chk("held_lat1", longint'(n), 38);
        chk_near("held_y1", longint'(y_out), 64'h555555);
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_y = nr_model(24'h900000);
        chk("accept_after_done", longint'(busy), 1);
        wait_done(n, got);
        chk("held_lat2", longint'(n), 38);
        chk_near("held_y2", longint'(y_out), ideal(24'h900000));

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nr_recip_ctrl.md
Name: nr_recip_ctrl

Overview:
- Newton-Raphson reciprocal controller. Computes y = 1/d for a normalized unsigned divisor d in [0.5, 1).
- Sits directly upstream of the 24x24 sequential multiplier. It drives the multiplier's start and operands and consumes its 48-bit product through the start/ready handshake.
- Iterates x(n+1) = x(n)*(2 - d*x(n)): two multiplier operations per iteration, seeded by a linear estimate.

Parameters:
- ITER, 3: number of NR iterations, range 1..4. 3 iterations take the ~4-bit seed past 24 bits.
- INIT_C, 24'hBA8241: seed constant 2.9142 in Q2.22.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled in IDLE only
- d_in  in  24  divisor, Q0.24 unsigned; latched on accepted start
- busy  out  1  high from the accept edge until done is asserted
- done  out  1  one-cycle pulse; y_out and err valid while done is high and held until the next accept
- err  out  1  d_in[23]==0 (not normalized)
- y_out  out  24  reciprocal, Q2.22 unsigned
- mul_start  out  1  one-cycle multiplier start pulse
- mul_a  out  24  multiplier operand A; held stable for the whole operation
- mul_b  out  24  multiplier operand B; held stable for the whole operation
- mul_ready  in  1  multiplier ready; drops the cycle after start, rises when the product is valid
- mul_p  in  48  multiplier product

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - busy, done, err, mul_start = 0.
  - y_out, mul_a, mul_b, and the internal d and x registers = 0.
  - Reset mid-operation abandons the computation; no done is produced.
- States: IDLE, SEED, M1_REQ, M1_WAIT, M2_REQ, M2_WAIT, FIN; iteration counter it.
- IDLE:
  - start=1 latches d and goes to SEED; busy=1, done=0.
  - If d_in[23]=0: go to FIN with err=1 and y_out=24'hFFFFFF; no multiplier activity.
  - start while busy is ignored.
- SEED: x = INIT_C - (d>>1) (2d in Q2.22); it=0; go to M1_REQ.
- M1_REQ:
  - Drive mul_a=d, mul_b=x.
  - Assert mul_start only if mul_ready=1, then go to M1_WAIT. Otherwise stay in M1_REQ; this covers a multiplier still finishing after our reset.
- M1_WAIT:
  - Operands held. On mul_ready=1: e = mul_p[47:24] (Q2.22).
  - t = 24'h800000 - e, clamped to 0 if e > 24'h800000.
  - Go to M2_REQ.
- M2_REQ: mul_a=x, mul_b=t; same start rule as M1_REQ; go to M2_WAIT.
- M2_WAIT: on mul_ready=1:
  - x = mul_p[45:22], or 24'hFFFFFF if mul_p[47:46]!=0.
  - If it==ITER-1, go to FIN; otherwise it++ and go to M1_REQ.
- FIN: y_out = x (or saturated value on err); done=1 for one cycle; busy=0; go to IDLE.
- Operand stability: mul_a/mul_b change only in REQ states and never while the multiplier is busy. The multiplier reads its operands in every phase.
- mul_start is never high for two consecutive cycles and never high outside the REQ states.
- Latency with a multiplier whose ready rises 5 edges after its start cycle: done high 2 + 12*ITER edges after the start edge, i.e. 38 for ITER=3.
- Accuracy: |y_out - 2^22/d| <= 2 LSB (Q2.22) for all normalized d. Truncation only, no rounding.
- Simultaneous events: start in the FIN cycle is ignored; a new start is accepted the following IDLE cycle.

Decomposition:
- Package nr_pkg holds:
  - the state enum type;
  - localparams TWO_Q222=24'h800000, SAT_Q222=24'hFFFFFF, default INIT_C;
  - the Q-format slice indices (E_HI=47, E_LO=24, X_HI=45, X_LO=22).
- One sub-module: nr_post. Combinational product slicing, the 2-e clamp and Q2.22 saturation, shared by both WAIT states.
- The bench instantiates the real sequential multiplier as the downstream stage.

Test Plan:
- Reset, then start with d_in=24'h800000 (0.5) -> 38 cycles later done=1, y_out within 2 LSB of 24'h800000, err=0.
- d_in=24'hC00000 (0.75) -> y_out within 2 LSB of 24'h555555.
- d_in=24'hFFFFFF -> y_out within 2 LSB of 24'h400000. mul_start pulses exactly 6 times, each one cycle; mul_a/mul_b are constant between each pulse and the following mul_ready rise.
- d_in=24'h3FFFFF (unnormalized) -> done 2 cycles after start, err=1, y_out=24'hFFFFFF, mul_start never asserted.
- Assert rst during the second M2_WAIT -> all outputs 0 immediately with no done. A new start with d_in=24'hA00000 yields y_out within 2 LSB of 24'h666666.
- Pulse start again while busy with a different d_in -> ignored; the result matches the first operand; the next start after done is accepted.
